// File: rtl/data_cache_wb.sv
// data_cache_wb: direct-mapped, write-back, write-allocate L1 data cache with 128-bit block refills.
// Optional macro DCACHE_PERF_CNT_EN adds hit_count/miss_count/wb_count event counters.
module data_cache_wb #(
   parameter int unsigned NUM_LINES   = 8,
   parameter int unsigned BLOCK_WORDS = 4
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic                      read,
   input  logic                      write,
   input  logic [31:0]               address,
   input  logic [31:0]               writedata,
   output logic [31:0]               readdata,
   output logic                      busywait,
   output logic                      mem_Read,
   output logic                      mem_Write,
   output logic [27:0]               mem_Address,
   output logic [BLOCK_WORDS*32-1:0] mem_Writedata,
   input  logic [BLOCK_WORDS*32-1:0] mem_Readdata,
   input  logic                      mem_BusyWait
`ifdef DCACHE_PERF_CNT_EN
   ,
   output logic [31:0]               hit_count,
   output logic [31:0]               miss_count,
   output logic [31:0]               wb_count
`endif
);

   localparam int unsigned INDEX_W = $clog2(NUM_LINES);
   localparam int unsigned TAG_W   = 28 - INDEX_W;
   localparam int unsigned LINE_W  = BLOCK_WORDS * 32;

   typedef enum logic [1:0] {StIdle, StWriteback, StMemRead, StUpdate} state_e;

   state_e              r_state;
   state_e              w_state_next;
   logic                r_valid [NUM_LINES];
   logic                r_dirty [NUM_LINES];
   logic [TAG_W-1:0]    r_tag   [NUM_LINES];
   logic [LINE_W-1:0]   r_data  [NUM_LINES];
   logic [27:0]         r_miss_blk;
   logic [LINE_W-1:0]   r_fill;

   logic [INDEX_W-1:0]  w_index;
   logic [TAG_W-1:0]    w_tag;
   logic [1:0]          w_offset;
   logic                w_req;
   logic                w_hit;
   logic [INDEX_W-1:0]  w_miss_idx;
   logic [TAG_W-1:0]    w_miss_tag;
   logic                w_unused;

   assign w_index    = address[4 +: INDEX_W];
   assign w_tag      = address[31 -: TAG_W];
   assign w_offset   = address[3:2];
   assign w_req      = read | write;
   assign w_hit      = r_valid[w_index] && (r_tag[w_index] == w_tag);
   assign w_miss_idx = r_miss_blk[INDEX_W-1:0];
   assign w_miss_tag = r_miss_blk[27 -: TAG_W];
   assign w_unused   = ^address[1:0];

   always_comb begin
      w_state_next  = r_state;
      busywait      = 1'b0;
      mem_Read      = 1'b0;
      mem_Write     = 1'b0;
      mem_Address   = '0;
      mem_Writedata = '0;
      readdata      = r_data[w_index][{w_offset, 5'd0} +: 32];
      unique case (r_state)
         StIdle: begin
            if (w_req && !w_hit) begin
               busywait     = 1'b1;
               w_state_next = (r_valid[w_index] && r_dirty[w_index]) ? StWriteback : StMemRead;
            end
         end
         StWriteback: begin
            busywait      = 1'b1;
            mem_Write     = 1'b1;
            mem_Address   = {r_tag[w_miss_idx], w_miss_idx};
            mem_Writedata = r_data[w_miss_idx];
            if (!mem_BusyWait) w_state_next = StMemRead;
         end
         StMemRead: begin
            busywait    = 1'b1;
            mem_Read    = 1'b1;
            mem_Address = r_miss_blk;
            if (!mem_BusyWait) w_state_next = StUpdate;
         end
         StUpdate: begin
            busywait     = 1'b1;
            w_state_next = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   // Miss block address is latched so a request dropped mid-miss cannot corrupt the refill.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state    <= StIdle;
         r_miss_blk <= '0;
         for (int i = 0; i < NUM_LINES; i++) begin
            r_valid[i] <= 1'b0;
            r_dirty[i] <= 1'b0;
         end
      end else begin
         r_state <= w_state_next;
         if (r_state == StIdle && w_req) begin
            if (!w_hit) r_miss_blk <= address[31:4];
            else if (write) r_dirty[w_index] <= 1'b1;
         end
         if (r_state == StUpdate) begin
            r_valid[w_miss_idx] <= 1'b1;
            r_dirty[w_miss_idx] <= 1'b0;
         end
      end
   end

   // Data and tag arrays are not cleared by reset; valid bits alone guard them.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         if (r_state == StIdle && w_req && w_hit && write) begin
            r_data[w_index][{w_offset, 5'd0} +: 32] <= writedata;
         end
         if (r_state == StMemRead && !mem_BusyWait) r_fill <= mem_Readdata;
         if (r_state == StUpdate) begin
            r_data[w_miss_idx] <= r_fill;
            r_tag[w_miss_idx]  <= w_miss_tag;
         end
      end
   end

`ifdef DCACHE_PERF_CNT_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;
   logic [31:0] r_wb_cnt;
   logic        r_post_fill;

   // The hit that completes a refilled request was already counted as a miss.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_hit_cnt   <= '0;
         r_miss_cnt  <= '0;
         r_wb_cnt    <= '0;
         r_post_fill <= 1'b0;
      end else begin
         r_post_fill <= (r_state == StUpdate);
         if (r_state == StIdle && w_req) begin
            if (!w_hit) r_miss_cnt <= r_miss_cnt + 32'd1;
            else if (!r_post_fill) r_hit_cnt <= r_hit_cnt + 32'd1;
         end
         if (r_state == StIdle && w_state_next == StWriteback) r_wb_cnt <= r_wb_cnt + 32'd1;
      end
   end

   assign hit_count  = r_hit_cnt;
   assign miss_count = r_miss_cnt;
   assign wb_count   = r_wb_cnt;
`endif

endmodule
